// File: rtl/vga_scanout.sv
// VGA 640x480@60 scanout of a 160x120 RGB332 framebuffer.
// Pixel clock is clk/2; one register stage between counters and pins.
module vga_scanout #(
    parameter int unsigned FB_BASE        = 0,
    parameter int unsigned FB_WIDTH_WORDS = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [12:0] vaddr,
    output logic [1:0]  vbyte,
    input  logic [31:0] vdata,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        frame_start
);

    localparam logic [9:0] H_VIS = 10'd640;
    localparam logic [9:0] H_SS  = 10'd656;
    localparam logic [9:0] H_SE  = 10'd751;
    localparam logic [9:0] H_MAX = 10'd799;
    localparam logic [9:0] V_VIS = 10'd480;
    localparam logic [9:0] V_SS  = 10'd490;
    localparam logic [9:0] V_SE  = 10'd491;
    localparam logic [9:0] V_MAX = 10'd524;

    logic       pix_en_q, pix_en_d;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [7:0] pix_q, pix_d;
    logic       vis_q, vis_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       fs_q, fs_d;

    logic       tick;
    logic       visible;
    logic [7:0] sel_byte;

    assign tick    = pix_en_q;
    assign visible = (hc_q < H_VIS) && (vc_q < V_VIS);

    // Each word holds 4 fb pixels, each fb pixel spans 4 screen pixels.
    always_comb begin
        vaddr = 13'(FB_BASE);
        vbyte = 2'd0;
        if (visible) begin
            vaddr = 13'(FB_BASE)
                  + 13'(vc_q[9:2]) * 13'(FB_WIDTH_WORDS)
                  + 13'(hc_q[9:4]);
            vbyte = hc_q[3:2];
        end
    end

    always_comb begin
        sel_byte = vdata[7:0];
        unique case (vbyte)
            2'd0: sel_byte = vdata[7:0];
            2'd1: sel_byte = vdata[15:8];
            2'd2: sel_byte = vdata[23:16];
            2'd3: sel_byte = vdata[31:24];
            default: sel_byte = vdata[7:0];
        endcase
    end

    always_comb begin
        pix_en_d = ~pix_en_q;
        hc_d     = hc_q;
        vc_d     = vc_q;
        pix_d    = pix_q;
        vis_d    = vis_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        fs_d     = 1'b0;
        if (tick) begin
            if (hc_q == H_MAX) begin
                hc_d = 10'd0;
                vc_d = (vc_q == V_MAX) ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
            pix_d = sel_byte;
            vis_d = visible;
            hs_d  = (hc_q >= H_SS) && (hc_q <= H_SE);
            vs_d  = (vc_q >= V_SS) && (vc_q <= V_SE);
            fs_d  = (hc_q == H_MAX) && (vc_q == V_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_en_q <= 1'b0;
            hc_q     <= 10'd0;
            vc_q     <= 10'd0;
            pix_q    <= 8'd0;
            vis_q    <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            pix_en_q <= pix_en_d;
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            pix_q    <= pix_d;
            vis_q    <= vis_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fs_q     <= fs_d;
        end
    end

    assign VGA_R       = vis_q ? {pix_q[7:5], pix_q[7]} : 4'd0;
    assign VGA_G       = vis_q ? {pix_q[4:2], pix_q[4]} : 4'd0;
    assign VGA_B       = vis_q ? {pix_q[1:0], pix_q[1:0]} : 4'd0;
    assign VGA_HS      = ~hs_q;
    assign VGA_VS      = ~vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: screen-position model checked every clk,
// plus literal checks on sync periods, pixel colours and resets.
module tb_vga_scanout;

    localparam int B = 256;
    localparam int W = 40;
    localparam int FRAME = 420000;

    logic        clk;
    logic        rst_n;
    logic [12:0] vaddr;
    logic [1:0]  vbyte;
    logic [31:0] vdata;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, fstart;

    int n;
    int cyc;
    int phase;
    int asserts;
    int errs;
    int fs_cnt;
    int last_hf, last_vf;
    logic prev_hs, prev_vs;
    logic [31:0] seed;

    vga_scanout #(.FB_BASE(B), .FB_WIDTH_WORDS(W)) dut (
        .clk(clk), .reset_n(rst_n), .vaddr(vaddr), .vbyte(vbyte),
        .vdata(vdata), .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .VGA_HS(vga_hs), .VGA_VS(vga_vs), .frame_start(fstart)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic logic [31:0] word(int a);
        if (a == B) return 32'hE01C0300;
        if (phase == 1) return 32'd0;
        return (32'(a) * 32'h9E3779B1) ^ seed;
    endfunction

    // Expected pin state after n rising edges since reset release.
    function automatic logic [29:0] expv();
        int p, x, y, q, qx, qy, pix, k;
        int ea, eb, r, g, b, hs, vs, fs;
        logic [31:0] w;
        ea = B; eb = 0; r = 0; g = 0; b = 0;
        hs = 1; vs = 1; fs = 0;
        if (rst_n) begin
            p = (n / 2) % FRAME;
            x = p % 800;
            y = p / 800;
            if (x < 640 && y < 480) begin
                ea = B + (y / 4) * W + (x / 4) / 4;
                eb = (x / 4) % 4;
            end
            if (n >= 2) begin
                q  = (n / 2 - 1) % FRAME;
                qx = q % 800;
                qy = q / 800;
                if (qx < 640 && qy < 480) begin
                    w   = word(B + (qy / 4) * W + (qx / 4) / 4);
                    k   = (qx / 4) % 4;
                    pix = int'((w >> (8 * k)) & 32'hFF);
                    r   = (pix >> 5) * 2 + (pix >> 7);
                    g   = ((pix >> 2) & 7) * 2 + ((pix >> 4) & 1);
                    b   = (pix & 3) * 4 + (pix & 3);
                end
                hs = (qx >= 656 && qx <= 751) ? 0 : 1;
                vs = (qy >= 490 && qy <= 491) ? 0 : 1;
                fs = (n % 2 == 0 && (n / 2) % FRAME == 0) ? 1 : 0;
            end
        end
        return {13'(ea), 2'(eb), 4'(r), 4'(g), 4'(b), 1'(hs), 1'(vs), 1'(fs)};
    endfunction

    function automatic logic [29:0] dutv();
        return {vaddr, vbyte, vga_r, vga_g, vga_b, vga_hs, vga_vs, fstart};
    endfunction

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, errs);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (n=%0d phase=%0d)",
                     name, act, exp, n, phase);
            if (errs >= 40) begin
                summary();
                $finish;
            end
        end
    endtask

    // One clk: compare at the falling edge, then drive the RAM for the next edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rst_n) n++;
        chk("pins", 32'(dutv()), 32'(expv()));
        if (rst_n && n >= 2) begin
            if (prev_hs && !vga_hs) begin
                if (last_hf >= 0) chk("hs_period", 32'(cyc - last_hf), 32'd1600);
                last_hf = cyc;
            end
            if (!prev_hs && vga_hs && last_hf >= 0)
                chk("hs_low_width", 32'(cyc - last_hf), 32'd192);
            if (prev_vs && !vga_vs) last_vf = cyc;
            if (!prev_vs && vga_vs && last_vf >= 0)
                chk("vs_low_width", 32'(cyc - last_vf), 32'd3200);
            if (fstart) fs_cnt++;
        end
        prev_hs = vga_hs;
        prev_vs = vga_vs;
        if ((n + 1) % 2 == 0 || phase == 1)
            vdata = word(int'(vaddr));
        else
            vdata = $urandom;
    endtask

    task automatic run_to(int target);
        while (n < target) step();
    endtask

    initial begin
        asserts = 0; errs = 0; n = 0; cyc = 0; fs_cnt = 0;
        last_hf = -1; last_vf = -1;
        prev_hs = 1'b1; prev_vs = 1'b1;
        seed = $urandom;
        phase = 1;
        vdata = 32'd0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        run_to(2);
        chk("rgb_px0", 32'({vga_r, vga_g, vga_b}), 32'h000);
        run_to(10);
        chk("rgb_px4", 32'({vga_r, vga_g, vga_b}), 32'h00F);
        run_to(18);
        chk("rgb_px8", 32'({vga_r, vga_g, vga_b}), 32'h0F0);
        run_to(26);
        chk("rgb_px12", 32'({vga_r, vga_g, vga_b}), 32'hF00);
        run_to(320600);
        chk("vaddr_300_200", 32'(vaddr), 32'(B + 2018));
        chk("vbyte_300_200", 32'(vbyte), 32'd3);
        chk("fs_none_yet", 32'(fs_cnt), 32'd0);

        #3 rst_n = 1'b0;
        #1 chk("async_reset",
               32'({vaddr, vbyte, vga_r, vga_g, vga_b, vga_hs, vga_vs, fstart}),
               32'({13'(B), 2'd0, 12'd0, 1'b1, 1'b1, 1'b0}));
        n = 0;
        last_hf = -1; last_vf = -1;
        repeat (2) step();
        phase = 2;
        rst_n = 1'b1;

        run_to(1);
        chk("restart_vaddr", 32'(vaddr), 32'(B));
        run_to(767678);
        chk("vaddr_639_479", 32'(vaddr), 32'(B + 4799));
        chk("vbyte_639_479", 32'(vbyte), 32'd3);
        run_to(767680);
        chk("vaddr_640_479", 32'(vaddr), 32'(B));
        run_to(767682);
        chk("rgb_640_479", 32'({vga_r, vga_g, vga_b}), 32'h000);
        run_to(839999);
        chk("fs_before", 32'(fstart), 32'd0);
        run_to(840000);
        chk("fs_pulse", 32'(fstart), 32'd1);
        chk("fs_at_origin", 32'(vaddr), 32'(B));
        run_to(840001);
        chk("fs_width", 32'(fstart), 32'd0);
        run_to(843400);
        chk("fs_count", 32'(fs_cnt), 32'd1);

        summary();
        $finish;
    end

endmodule
